// File: rtl/bolt_pool_ctrl.sv
// Four-slot bolt pool: spawns bolts on fire requests, moves them once per frame,
// retires them off-screen or on hit, and drives the per-bolt rectangle outputs.
module bolt_pool_ctrl #(
   parameter int OBJECT_WIDTH_X  = 4,
   parameter int OBJECT_HEIGHT_Y = 16,
   parameter int SPEED_Y         = 4,
   parameter int SCREEN_H        = 480,
   parameter int COOLDOWN        = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             startOfFrame,
   input  logic [10:0]      pixelX,
   input  logic [10:0]      pixelY,
   input  logic             fireReq,
   input  logic [10:0]      fireX,
   input  logic [10:0]      fireY,
   input  logic             collision,
   output logic [3:0][10:0] offsetX,
   output logic [3:0][10:0] offsetY,
   output logic [3:0]       inRect,
   output logic [3:0]       boltActive,
   output logic             fireAck
);

   localparam int                 CW          = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
   localparam logic [CW-1:0]      COOL_RELOAD = CW'(COOLDOWN);
   localparam logic signed [11:0] SPEED12     = 12'(SPEED_Y);
   localparam logic signed [12:0] SCREEN13    = 13'(SCREEN_H);
   localparam logic signed [12:0] HEIGHT13S   = 13'(OBJECT_HEIGHT_Y);
   localparam logic [12:0]        HEIGHT13U   = 13'(OBJECT_HEIGHT_Y);
   localparam logic [11:0]        WIDTH12     = 12'(OBJECT_WIDTH_X);

   typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1, HIT = 2'd2} slotState_t;

   slotState_t         state_q [4];
   logic [10:0]        topX_q [4];
   logic signed [11:0] topY_q [4];
   logic [CW-1:0]      cool_q;
   logic [3:0]         inRect_q;
   logic [3:0]         inRectDly_q;
   logic [3:0][10:0]   offX_q;
   logic [3:0][10:0]   offY_q;
   logic               fireAck_q;

   logic [3:0]         idleVec;
   logic [3:0]         insideVec;
   logic [3:0]         offScreen;
   logic [3:0][10:0]   offX_d;
   logic [3:0][10:0]   offY_d;
   logic signed [11:0] movedY [4];
   logic signed [12:0] movedExt [4];
   logic [12:0]        topYU [4];
   logic [1:0]         freeIdx;
   logic               accept;

   // Rectangle hits use unsigned 12/13-bit compares so a negative topY never matches a wrapped row.
   always_comb begin
      idleVec   = '0;
      insideVec = '0;
      offScreen = '0;
      offX_d    = '0;
      offY_d    = '0;
      freeIdx   = '0;
      for (int i = 0; i < 4; i++) begin
         idleVec[i]   = (state_q[i] == IDLE);
         movedY[i]    = topY_q[i] + SPEED12;
         movedExt[i]  = {movedY[i][11], movedY[i]};
         offScreen[i] = (movedExt[i] >= SCREEN13) || ((movedExt[i] + HEIGHT13S) <= 13'sd0);
         topYU[i]     = {1'b0, $unsigned(topY_q[i])};
         insideVec[i] = (state_q[i] == FLYING)
                        && ({1'b0, pixelX} >= {1'b0, topX_q[i]})
                        && ({1'b0, pixelX} < ({1'b0, topX_q[i]} + WIDTH12))
                        && ({2'b00, pixelY} >= topYU[i])
                        && ({2'b00, pixelY} < (topYU[i] + HEIGHT13U));
         if (insideVec[i]) begin
            offX_d[i] = pixelX - topX_q[i];
            offY_d[i] = 11'({1'b0, pixelY} - $unsigned(topY_q[i]));
         end
      end
      for (int i = 3; i >= 0; i--) begin
         if (idleVec[i]) freeIdx = 2'(i);
      end
      accept = fireReq && (cool_q == '0) && (|idleVec);
   end

   // Collision is attributed through inRectDly_q, which lines up with the drawer's RGB latency.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= IDLE;
            topX_q[i]  <= '0;
            topY_q[i]  <= '0;
         end
         cool_q      <= '0;
         inRect_q    <= '0;
         inRectDly_q <= '0;
         offX_q      <= '0;
         offY_q      <= '0;
         fireAck_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case (state_q[i])
               IDLE: begin
                  if (accept && (freeIdx == 2'(i))) begin
                     state_q[i] <= FLYING;
                     topX_q[i]  <= fireX;
                     topY_q[i]  <= {1'b0, fireY};
                  end
               end
               FLYING: begin
                  if (collision && inRectDly_q[i]) begin
                     state_q[i] <= HIT;
                  end else if (startOfFrame) begin
                     if (offScreen[i]) state_q[i] <= IDLE;
                     else              topY_q[i]  <= movedY[i];
                  end
               end
               HIT: begin
                  if (startOfFrame) state_q[i] <= IDLE;
               end
               default: state_q[i] <= IDLE;
            endcase
         end
         if (accept)                                 cool_q <= COOL_RELOAD;
         else if (startOfFrame && (cool_q != '0))    cool_q <= cool_q - 1'b1;
         fireAck_q   <= accept;
         inRect_q    <= insideVec;
         inRectDly_q <= inRect_q;
         offX_q      <= offX_d;
         offY_q      <= offY_d;
      end
   end

   always_comb begin
      boltActive = '0;
      for (int i = 0; i < 4; i++) boltActive[i] = (state_q[i] == FLYING);
   end

   assign inRect  = inRect_q;
   assign offsetX = offX_q;
   assign offsetY = offY_q;
   assign fireAck = fireAck_q;

endmodule
